// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the per-core request ports and the single-port
// memory port of mem_arbiter.
//   core_req/core_we/core_addr/core_wdata : per-core requests (core i packed at i*W)
//   core_gnt/core_done                    : one-hot acceptance / completion pulses
//   core_rdata                            : read data, valid with core_done of a read
//   owner/busy                            : currently served core, FSM not idle
//   mem_*                                 : memory strobes, address, data
// slave  : arbiter side.  master : core/memory side.
interface mem_arbiter_if #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32
);
  localparam int OWN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_gnt;
  logic [NUM_CORES-1:0]        core_done;
  logic [DATA_W-1:0]           core_rdata;
  logic [OWN_W-1:0]            owner;
  logic                        busy;
  logic                        mem_en;
  logic                        mem_write;
  logic                        mem_read;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_data_in;
  logic [DATA_W-1:0]           mem_data_out;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_data_out,
    output core_gnt, core_done, core_rdata, owner, busy,
           mem_en, mem_write, mem_read, mem_addr, mem_data_in
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_data_out,
    input  core_gnt, core_done, core_rdata, owner, busy,
           mem_en, mem_write, mem_read, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter letting NUM_CORES cores share one
// single-port memory. Each access: IDLE (arbitrate, capture) -> ACCESS
// (grant + memory strobe) -> [WAIT for RD_LAT cycles on reads] -> DONE.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (aborts any access, no done pulse)
//   bus  : mem_arbiter_if.slave, core request side and memory side
module mem_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int OWN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [OWN_W-1:0]    owner_q;
  logic [OWN_W-1:0]    last_owner_q;
  logic [OWN_W-1:0]    win;
  logic                win_vld;
  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;

  // Round robin as two passes instead of a modulo rotation: the lowest
  // requester above last_owner wins, otherwise the lowest requester overall.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned j = 0; j < NUM_CORES; j++) begin
      if (!win_vld && bus.core_req[j] && (j > 32'(last_owner_q))) begin
        win_vld = 1'b1;
        win     = OWN_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_CORES; j++) begin
      if (!win_vld && bus.core_req[j]) begin
        win_vld = 1'b1;
        win     = OWN_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = ACCESS;
      ACCESS:  state_d = cap_we ? DONE : WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OWN_W'(NUM_CORES - 1);
      cap_we       <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            owner_q   <= win;
            cap_we    <= bus.core_we[win];
            cap_addr  <= bus.core_addr[win*ADDR_W +: ADDR_W];
            cap_wdata <= bus.core_wdata[win*DATA_W +: DATA_W];
          end
        end
        ACCESS: cnt_q <= CNT_W'(RD_LAT - 1);
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) rdata_q <= bus.mem_data_out;
        end
        DONE:    last_owner_q <= owner_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.core_gnt  = '0;
    bus.core_done = '0;
    bus.mem_en    = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    case (state_q)
      ACCESS: begin
        bus.core_gnt[owner_q] = 1'b1;
        bus.mem_en            = 1'b1;
        bus.mem_write         = cap_we;
        bus.mem_read          = !cap_we;
      end
      DONE:    bus.core_done[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_addr    = cap_addr;
  assign bus.mem_data_in = cap_wdata;
  assign bus.core_rdata  = rdata_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances with different NUM_CORES / RD_LAT,
// each with a latency-accurate memory read model and a completion scoreboard.
module tb_mem_arbiter;
  typedef struct {
    int          core;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst22 = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [11:0] a);
    return (a == 12'h020) ? 32'h12345678 : {20'hA5A5A, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  mem_arbiter_if #(.NUM_CORES(2), .ADDR_W(12), .DATA_W(32)) i21();
  mem_arbiter_if #(.NUM_CORES(2), .ADDR_W(12), .DATA_W(32)) i22();
  mem_arbiter_if #(.NUM_CORES(4), .ADDR_W(12), .DATA_W(32)) i4();
  mem_arbiter_if #(.NUM_CORES(1), .ADDR_W(12), .DATA_W(32)) i1();

  mem_arbiter #(.NUM_CORES(2), .ADDR_W(12), .DATA_W(32), .RD_LAT(1)) u21 (.clk(clk), .rst(rst),   .bus(i21));
  mem_arbiter #(.NUM_CORES(2), .ADDR_W(12), .DATA_W(32), .RD_LAT(2)) u22 (.clk(clk), .rst(rst22), .bus(i22));
  mem_arbiter #(.NUM_CORES(4), .ADDR_W(12), .DATA_W(32), .RD_LAT(1)) u4  (.clk(clk), .rst(rst),   .bus(i4));
  mem_arbiter #(.NUM_CORES(1), .ADDR_W(12), .DATA_W(32), .RD_LAT(4)) u1  (.clk(clk), .rst(rst),   .bus(i1));

  // Memory read models: data is only valid exactly RD_LAT cycles after mem_en.
  logic [31:0] p21 [1]; logic v21 [1];
  logic [31:0] p22 [2]; logic v22 [2];
  logic [31:0] p4  [1]; logic v4  [1];
  logic [31:0] p1  [4]; logic v1  [4];

  always @(posedge clk) begin
    if (rst) v21[0] <= 1'b0; else v21[0] <= i21.mem_en & i21.mem_read;
    p21[0] <= model(i21.mem_addr);
    if (rst) v4[0] <= 1'b0; else v4[0] <= i4.mem_en & i4.mem_read;
    p4[0] <= model(i4.mem_addr);
    if (rst22) begin v22[0] <= 1'b0; v22[1] <= 1'b0; end
    else begin v22[0] <= i22.mem_en & i22.mem_read; v22[1] <= v22[0]; end
    p22[0] <= model(i22.mem_addr);
    p22[1] <= p22[0];
    if (rst) for (int k = 0; k < 4; k++) v1[k] <= 1'b0;
    else begin
      v1[0] <= i1.mem_en & i1.mem_read;
      for (int k = 1; k < 4; k++) v1[k] <= v1[k-1];
    end
    p1[0] <= model(i1.mem_addr);
    for (int k = 1; k < 4; k++) p1[k] <= p1[k-1];
  end

  assign i21.mem_data_out = v21[0] ? p21[0] : 32'hBAD0BAD0;
  assign i22.mem_data_out = v22[1] ? p22[1] : 32'hBAD0BAD0;
  assign i4.mem_data_out  = v4[0]  ? p4[0]  : 32'hBAD0BAD0;
  assign i1.mem_data_out  = v1[3]  ? p1[3]  : 32'hBAD0BAD0;

  // Scoreboards
  exp_t q21[$], q22[$], q4[$], q1[$];
  int   g4[$];
  exp_t e21, e22, e4, e1;
  int   eg4;

  always @(negedge clk) begin
    if (|i21.core_done) begin
      if (q21.size() == 0) check("d21_unexp_done", i21.core_done, 0);
      else begin
        e21 = q21.pop_front();
        check("d21_done", i21.core_done, 64'd1 << e21.core);
        if (e21.rd) check("d21_rdata", i21.core_rdata, e21.data);
      end
    end
    if (|i22.core_done) begin
      if (q22.size() == 0) check("d22_unexp_done", i22.core_done, 0);
      else begin
        e22 = q22.pop_front();
        check("d22_done", i22.core_done, 64'd1 << e22.core);
        if (e22.rd) check("d22_rdata", i22.core_rdata, e22.data);
      end
    end
    if (|i4.core_done) begin
      if (q4.size() == 0) check("d4_unexp_done", i4.core_done, 0);
      else begin
        e4 = q4.pop_front();
        check("d4_done", i4.core_done, 64'd1 << e4.core);
        if (e4.rd) check("d4_rdata", i4.core_rdata, e4.data);
      end
    end
    if (|i4.core_gnt) begin
      if (g4.size() == 0) check("d4_unexp_gnt", i4.core_gnt, 0);
      else begin
        eg4 = g4.pop_front();
        check("d4_gnt_order", i4.core_gnt, 64'd1 << eg4);
        check("d4_owner", i4.owner, eg4);
      end
    end
    if (|i1.core_done) begin
      if (q1.size() == 0) check("d1_unexp_done", i1.core_done, 0);
      else begin
        e1 = q1.pop_front();
        check("d1_done", i1.core_done, 1);
        if (e1.rd) check("d1_rdata", i1.core_rdata, e1.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit          ops_we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [11:0] ops_a  [4] = '{12'h020, 12'h050, 12'h051, 12'h052};

  initial begin
    int ng;
    int k;
    int lat;

    i21.core_req = '0; i21.core_we = '0; i21.core_addr = '0; i21.core_wdata = '0;
    i22.core_req = '0; i22.core_we = '0; i22.core_addr = '0; i22.core_wdata = '0;
    i1.core_req  = '0; i1.core_we  = '0; i1.core_addr  = '0; i1.core_wdata  = '0;
    // Fairness: all four cores request from reset; cores 1 and 3 write.
    i4.core_req = 4'hF; i4.core_we = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      i4.core_addr[c*12 +: 12]  = 12'h100 + 12'(c);
      i4.core_wdata[c*32 +: 32] = 32'hC0DE0000 + 32'(c);
    end
    g4.push_back(0); g4.push_back(1); g4.push_back(2); g4.push_back(3); g4.push_back(0);
    q4.push_back('{0, 1'b1, model(12'h100)});
    q4.push_back('{1, 1'b0, 32'h0});
    q4.push_back('{2, 1'b1, model(12'h102)});
    q4.push_back('{3, 1'b0, 32'h0});
    q4.push_back('{0, 1'b1, model(12'h100)});
    tick(); tick();

    check("rst_d4_busy", i4.busy, 0);
    check("rst_d4_gnt", i4.core_gnt, 0);
    check("rst_d4_mem_en", i4.mem_en, 0);
    check("rst_d22_addr", i22.mem_addr, 0);
    check("rst_d22_rdata", i22.core_rdata, 0);
    check("rst_d1_owner", i1.owner, 0);

    rst = 1'b0; rst22 = 1'b0;
    ng = 0;
    for (int cyc = 0; cyc < 80 && ng < 5; cyc++) begin
      tick();
      if (|i4.core_gnt) ng++;
    end
    check("d4_fair_grants", ng, 5);
    i4.core_req = '0;
    k = 0;
    while (i4.busy && k < 20) begin tick(); k++; end
    check("d4_idle_after_fair", i4.busy, 0);

    // Late arrival: core2 raises req during core0's WAIT, core0 re-requests.
    i4.core_req[0] = 1'b1; i4.core_we[0] = 1'b0; i4.core_addr[0 +: 12] = 12'h200;
    g4.push_back(0); q4.push_back('{0, 1'b1, model(12'h200)});
    tick();
    check("d4_late_first_gnt", i4.core_gnt, 4'b0001);
    i4.core_req[0] = 1'b0;
    tick();
    i4.core_req[2] = 1'b1; i4.core_we[2] = 1'b1; i4.core_addr[24 +: 12] = 12'h222;
    i4.core_req[0] = 1'b1; i4.core_addr[0 +: 12] = 12'h201;
    g4.push_back(2); g4.push_back(0);
    q4.push_back('{2, 1'b0, 32'h0});
    q4.push_back('{0, 1'b1, model(12'h201)});
    tick(); tick(); tick();
    check("d4_late_gnt2", i4.core_gnt, 4'b0100);
    i4.core_req[2] = 1'b0;
    k = 0;
    while (!i4.core_gnt[0] && k < 20) begin tick(); k++; end
    check("d4_late_gnt0", i4.core_gnt, 4'b0001);
    i4.core_req[0] = 1'b0;

    // Write on the RD_LAT=1 two-core instance.
    i21.core_req[0] = 1'b1; i21.core_we[0] = 1'b1;
    i21.core_addr[0 +: 12] = 12'h010; i21.core_wdata[0 +: 32] = 32'hDEADBEEF;
    q21.push_back('{0, 1'b0, 32'h0});
    tick();
    check("d21_gnt", i21.core_gnt, 2'b01);
    check("d21_mem_en", i21.mem_en, 1);
    check("d21_mem_write", i21.mem_write, 1);
    check("d21_mem_read", i21.mem_read, 0);
    check("d21_mem_addr", i21.mem_addr, 12'h010);
    check("d21_mem_data_in", i21.mem_data_in, 32'hDEADBEEF);
    i21.core_req = '0;
    tick();
    check("d21_done_t2", i21.core_done, 2'b01);
    check("d21_gnt_t2", i21.core_gnt, 0);
    check("d21_addr_hold", i21.mem_addr, 12'h010);
    tick();
    check("d21_busy_t3", i21.busy, 0);

    // Read on the RD_LAT=2 instance, then a write that must not touch rdata.
    i22.core_req[1] = 1'b1; i22.core_we[1] = 1'b0; i22.core_addr[12 +: 12] = 12'h020;
    q22.push_back('{1, 1'b1, 32'h12345678});
    tick();
    check("d22_gnt", i22.core_gnt, 2'b10);
    check("d22_mem_read_acc", i22.mem_read, 1);
    check("d22_mem_write_acc", i22.mem_write, 0);
    check("d22_owner", i22.owner, 1);
    i22.core_req = '0;
    tick();
    check("d22_mem_read_w1", i22.mem_read, 0);
    check("d22_done_w1", i22.core_done, 0);
    tick();
    check("d22_mem_en_w2", i22.mem_en, 0);
    check("d22_done_w2", i22.core_done, 0);
    tick();
    check("d22_done_t4", i22.core_done, 2'b10);
    check("d22_rdata_t4", i22.core_rdata, 32'h12345678);
    tick();
    i22.core_req[0] = 1'b1; i22.core_we[0] = 1'b1;
    i22.core_addr[0 +: 12] = 12'h030; i22.core_wdata[0 +: 32] = 32'h00000055;
    q22.push_back('{0, 1'b0, 32'h0});
    tick();
    check("d22_wr_gnt", i22.core_gnt, 2'b01);
    i22.core_req = '0;
    tick();
    check("d22_wr_done", i22.core_done, 2'b01);
    check("d22_rdata_kept", i22.core_rdata, 32'h12345678);
    tick();

    // Reset during WAIT of a core0 read: aborted, no done.
    i22.core_req[0] = 1'b1; i22.core_we[0] = 1'b0; i22.core_addr[0 +: 12] = 12'h040;
    tick();
    i22.core_req = '0;
    tick();
    rst22 = 1'b1;
    tick();
    rst22 = 1'b0;
    check("d22_rst_busy", i22.busy, 0);
    check("d22_rst_done", i22.core_done, 0);
    check("d22_rst_gnt", i22.core_gnt, 0);
    check("d22_rst_strobes", {i22.mem_en, i22.mem_write, i22.mem_read}, 0);
    check("d22_rst_addr", i22.mem_addr, 0);
    check("d22_rst_wdata", i22.mem_data_in, 0);
    check("d22_rst_rdata", i22.core_rdata, 0);
    check("d22_rst_owner", i22.owner, 0);
    tick();
    check("d22_rst_no_done", i22.core_done, 0);

    i22.core_req = 2'b11; i22.core_we = 2'b00;
    i22.core_addr[0 +: 12] = 12'h021; i22.core_addr[12 +: 12] = 12'h020;
    q22.push_back('{0, 1'b1, model(12'h021)});
    q22.push_back('{1, 1'b1, 32'h12345678});
    tick();
    check("d22_rr_after_rst", i22.core_gnt, 2'b01);
    i22.core_req[0] = 1'b0;
    k = 0;
    while (!i22.core_gnt[1] && k < 30) begin tick(); k++; end
    check("d22_b2b_spacing", k, 5);
    i22.core_req = '0;
    k = 0;
    while (i22.busy && k < 20) begin tick(); k++; end
    check("d22_idle_end", i22.busy, 0);

    // Single core, RD_LAT=4: alternating reads and writes.
    for (int n = 0; n < 4; n++) begin
      i1.core_req = 1'b1; i1.core_we = ops_we[n]; i1.core_addr = ops_a[n];
      i1.core_wdata = 32'h0BAD0000 + 32'(n);
      q1.push_back('{0, !ops_we[n], model(ops_a[n])});
      tick();
      check("d1_gnt", i1.core_gnt, 1);
      check("d1_rw", {i1.mem_read, i1.mem_write}, ops_we[n] ? 2'b01 : 2'b10);
      i1.core_req = 1'b0;
      lat = 1;
      while (!i1.core_done && lat < 20) begin
        tick();
        lat++;
        check("d1_owner", i1.owner, 0);
      end
      check("d1_latency", lat, ops_we[n] ? 2 : 6);
      tick();
      check("d1_idle", i1.busy, 0);
    end

    tick(); tick(); tick();
    check("d21_sb_drain", q21.size(), 0);
    check("d22_sb_drain", q22.size(), 0);
    check("d4_sb_drain", q4.size(), 0);
    check("d4_gnt_drain", g4.size(), 0);
    check("d1_sb_drain", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
